// File: rtl/serdes_var_if.sv
// rtl/serdes_var_if.sv - command, word-stream and buffer bundle for serdes_var
interface serdes_var_if #(
    parameter int W = 64,
    parameter int N = 4
);
    localparam int LW = $clog2(N + 1);

    logic          cmd_startDes;
    logic          cmd_startSer;
    logic [LW-1:0] cmd_numWords;
    logic          cmd_canReceive;
    logic          busy;
    logic [W*N-1:0] buffer_write;
    logic [W*N-1:0] buffer_read;
    logic [W-1:0]  des;
    logic          des_isReady;
    logic          des_canReceive;
    logic          des_isLast;
    logic [W-1:0]  ser;
    logic          ser_isReady;
    logic          ser_canReceive;
    logic          ser_isLast;

    modport master (
        output cmd_startDes, cmd_startSer, cmd_numWords, buffer_read,
               des, des_isReady, ser_canReceive,
        input  cmd_canReceive, busy, buffer_write, des_canReceive,
               des_isLast, ser, ser_isReady, ser_isLast
    );

    modport slave (
        input  cmd_startDes, cmd_startSer, cmd_numWords, buffer_read,
               des, des_isReady, ser_canReceive,
        output cmd_canReceive, busy, buffer_write, des_canReceive,
               des_isLast, ser, ser_isReady, ser_isLast
    );
endinterface

// File: rtl/serdes_var.sv
// rtl/serdes_var.sv - variable-length serialiser/deserialiser over an N-word external buffer
module serdes_var #(
    parameter int W = 64,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    serdes_var_if.slave  bus
);
    localparam int LW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, XFER, ALIGN} state_t;

    state_t        state, state_nxt;
    logic          is_ser_q, is_des_q;
    logic [LW-1:0] k_q, cnt_q, align_left_q;

    logic [LW-1:0] k_clamp, eff_k, eff_cnt;
    logic          accept, eff_ser, eff_des, active, step, last;
    logic [W*N-1:0] shifted, rotated, inserted;

    // Accept-cycle values are used directly so word 0 can move with zero latency
    always_comb begin
        k_clamp = (bus.cmd_numWords > LW'(N)) ? LW'(N) : bus.cmd_numWords;
        accept  = (state == IDLE) && !rst && (bus.cmd_startSer || bus.cmd_startDes);
        eff_ser = (state == IDLE) ? (accept && bus.cmd_startSer) : is_ser_q;
        eff_des = (state == IDLE) ? (accept && bus.cmd_startDes) : is_des_q;
        eff_k   = (state == IDLE) ? k_clamp : k_q;
        eff_cnt = (state == IDLE) ? '0 : cnt_q;
        active  = (state == XFER) || (accept && (k_clamp != '0));
        step    = active && (eff_des ? (bus.des_isReady && (!eff_ser || bus.ser_canReceive))
                                     : bus.ser_canReceive);
        last    = step && (eff_cnt == eff_k - LW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, XFER: begin
                if (active) begin
                    if (last) state_nxt = (eff_k == LW'(N)) ? IDLE : ALIGN;
                    else      state_nxt = XFER;
                end
            end
            ALIGN:   if (align_left_q == LW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_ser_q     <= 1'b0;
            is_des_q     <= 1'b0;
            k_q          <= '0;
            cnt_q        <= '0;
            align_left_q <= '0;
        end else begin
            if (accept && (k_clamp != '0)) begin
                is_ser_q <= bus.cmd_startSer;
                is_des_q <= bus.cmd_startDes;
                k_q      <= k_clamp;
            end
            if (step) cnt_q <= last ? '0 : eff_cnt + LW'(1);
            if (last) begin
                is_ser_q     <= 1'b0;
                is_des_q     <= 1'b0;
                align_left_q <= LW'(N) - eff_k;
            end else if (state == ALIGN) begin
                align_left_q <= align_left_q - LW'(1);
            end
        end
    end

    // Shift via >> so N=1 needs no empty part-select
    always_comb begin
        shifted  = bus.buffer_read >> W;
        rotated  = shifted;
        rotated[W*N-1 -: W]  = bus.buffer_read[W-1:0];
        inserted = shifted;
        inserted[W*N-1 -: W] = bus.des;

        bus.cmd_canReceive = (state == IDLE);
        bus.busy           = (state != IDLE) || active;
        bus.des_canReceive = eff_des && active && (!eff_ser || bus.ser_canReceive);
        bus.ser_isReady    = eff_ser && active && (eff_des ? bus.des_isReady : bus.ser_canReceive);
        bus.des_isLast     = last;
        bus.ser_isLast     = last;
        bus.ser            = bus.buffer_read[W-1:0];
        bus.buffer_write   = bus.buffer_read;
        if (state == ALIGN)  bus.buffer_write = rotated;
        else if (step)       bus.buffer_write = eff_des ? inserted : rotated;
    end
endmodule

// File: tb/tb_serdes_var.sv
// tb/tb_serdes_var.sv - scoreboard bench for serdes_var with W=8, N=4
module tb_serdes_var;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serdes_var_if #(.W(8), .N(4)) bus ();

    serdes_var #(.W(8), .N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [31:0] buf_q = 32'h0;
    logic        load_en = 1'b0;
    logic [31:0] load_val = 32'h0;
    assign bus.buffer_read = buf_q;
    always @(posedge clk) buf_q <= load_en ? load_val : bus.buffer_write;

    int checks = 0;
    int errors = 0;
    int ser_xfers = 0;
    int snap;
    logic [8:0] ser_q[$];
    logic       des_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] v);
        load_en  = 1'b1;
        load_val = v;
        tick();
        load_en  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.ser_isReady && bus.ser_canReceive) begin
            logic [8:0] e;
            ser_xfers++;
            if (ser_q.size() == 0) check("ser_unexpected", 1, 0);
            else begin
                e = ser_q.pop_front();
                check("ser_word", bus.ser, e[7:0]);
                check("ser_last", bus.ser_isLast, e[8]);
            end
        end
        if (bus.des_canReceive && bus.des_isReady) begin
            logic el;
            if (des_q.size() == 0) check("des_unexpected", 1, 0);
            else begin
                el = des_q.pop_front();
                check("des_last", bus.des_isLast, el);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cmd_startDes = 0; bus.cmd_startSer = 0; bus.cmd_numWords = 0;
        bus.des = 0; bus.des_isReady = 0; bus.ser_canReceive = 0;

        load(32'h44332211);
        #1;
        check("rst_canrx", bus.cmd_canReceive, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_desrx", bus.des_canReceive, 0);
        check("rst_serrdy", bus.ser_isReady, 0);
        check("rst_last", {bus.des_isLast, bus.ser_isLast}, 0);
        check("rst_bufw", bus.buffer_write, 32'h44332211);
        tick();
        rst = 1'b0;
        tick();

        // ser k=4
        ser_q.push_back(9'h011); ser_q.push_back(9'h022);
        ser_q.push_back(9'h033); ser_q.push_back(9'h144);
        bus.cmd_startSer = 1; bus.cmd_numWords = 4; bus.ser_canReceive = 1;
        #1 check("t1_busy", bus.busy, 1);
        tick();
        bus.cmd_startSer = 0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            #1 check("t1_canrx", bus.cmd_canReceive, i == 4);
        end
        check("t1_buf", buf_q, 32'h44332211);
        check("t1_q", ser_q.size(), 0);
        bus.ser_canReceive = 0;
        tick();

        // des k=2
        des_q.push_back(1'b0); des_q.push_back(1'b1);
        bus.cmd_startDes = 1; bus.cmd_numWords = 2; bus.des = 8'hAA; bus.des_isReady = 1;
        tick();
        bus.cmd_startDes = 0; bus.des = 8'hBB;
        #1 check("t2_desrx", bus.des_canReceive, 1);
        tick();
        bus.des_isReady = 0;
        #1 check("t2_align_canrx", bus.cmd_canReceive, 0);
        check("t2_align_busy", bus.busy, 1);
        tick();
        #1 check("t2_align2_canrx", bus.cmd_canReceive, 0);
        tick();
        #1 check("t2_canrx", bus.cmd_canReceive, 1);
        check("t2_buf", buf_q, 32'h4433BBAA);
        check("t2_q", des_q.size(), 0);

        // ser+des k=1 with consumer stalling
        load(32'h44332211);
        ser_q.push_back(9'h111); des_q.push_back(1'b1);
        bus.cmd_startSer = 1; bus.cmd_startDes = 1; bus.cmd_numWords = 1;
        bus.des = 8'hEE; bus.des_isReady = 1; bus.ser_canReceive = 0;
        #1 check("t3_hold", bus.des_canReceive, 0);
        tick();
        bus.cmd_startSer = 0; bus.cmd_startDes = 0; bus.ser_canReceive = 1;
        #1 check("t3_go", bus.des_canReceive, 1);
        tick();
        bus.des_isReady = 0; bus.ser_canReceive = 0;
        for (int i = 2; i <= 5; i++) begin
            if (i > 2) tick();
            #1 check("t3_canrx", bus.cmd_canReceive, i == 5);
        end
        check("t3_buf", buf_q, 32'h443322EE);

        // k=0 then k=7 (clamped to 4)
        snap = ser_xfers;
        bus.cmd_startSer = 1; bus.cmd_numWords = 0; bus.ser_canReceive = 1;
        #1 check("t4_k0_busy", bus.busy, 0);
        check("t4_k0_rdy", bus.ser_isReady, 0);
        tick();
        bus.cmd_startSer = 0;
        #1 check("t4_k0_canrx", bus.cmd_canReceive, 1);
        check("t4_k0_xfers", ser_xfers, snap);
        ser_q.push_back(9'h0EE); ser_q.push_back(9'h022);
        ser_q.push_back(9'h033); ser_q.push_back(9'h144);
        bus.cmd_startSer = 1; bus.cmd_numWords = 7;
        tick();
        bus.cmd_startSer = 0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            #1 check("t4_canrx", bus.cmd_canReceive, i == 4);
        end
        check("t4_buf", buf_q, 32'h443322EE);
        check("t4_xfers", ser_xfers, snap + 4);
        bus.ser_canReceive = 0;

        // reset during ALIGN of des k=1
        load(32'h44332211);
        des_q.push_back(1'b1);
        bus.cmd_startDes = 1; bus.cmd_numWords = 1; bus.des = 8'h55; bus.des_isReady = 1;
        tick();
        bus.cmd_startDes = 0; bus.des_isReady = 0;
        #1 check("t5_align", bus.cmd_canReceive, 0);
        rst = 1'b1;
        #1 check("t5_rst_canrx", bus.cmd_canReceive, 1);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_bufw", bus.buffer_write, 32'h55443322);
        tick();
        rst = 1'b0;
        #1 check("t5_rel_canrx", bus.cmd_canReceive, 1);
        check("t5_buf", buf_q, 32'h55443322);
        ser_q.push_back(9'h022); ser_q.push_back(9'h033);
        ser_q.push_back(9'h044); ser_q.push_back(9'h155);
        bus.cmd_startSer = 1; bus.cmd_numWords = 4; bus.ser_canReceive = 1;
        tick();
        bus.cmd_startSer = 0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            #1 check("t5_canrx", bus.cmd_canReceive, i == 4);
        end
        check("t5_buf2", buf_q, 32'h55443322);

        // start pulses during XFER are ignored
        snap = ser_xfers;
        ser_q.push_back(9'h022); ser_q.push_back(9'h033);
        ser_q.push_back(9'h044); ser_q.push_back(9'h155);
        bus.cmd_startSer = 1; bus.cmd_numWords = 4;
        tick();
        bus.cmd_startSer = 0;
        tick();
        bus.cmd_startSer = 1;
        #1 check("t6_canrx", bus.cmd_canReceive, 0);
        tick();
        bus.cmd_startSer = 0;
        tick();
        #1 check("t6_done", bus.cmd_canReceive, 1);
        bus.ser_canReceive = 0;
        tick();
        check("t6_xfers", ser_xfers, snap + 4);
        check("t6_buf", buf_q, 32'h55443322);
        check("end_serq", ser_q.size(), 0);
        check("end_desq", des_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serdes_var.md
Name: serdes_var

Overview:
- Variable-length serialiser/deserialiser between a W-bit word stream and an external N-word buffer.
- Successor to the fixed-length 64-bit serdes. Adds parametrised word width, a per-command word count k (0..N) and an automatic realignment phase.
- After any command the untouched words stay in their original positions, so partial loads and stores of a wide state register are possible.
- Sits between the streaming bus and the wide state registers.

Parameters:
- W, 64, word width in bits.
- N, 4, buffer depth in words (N >= 1).
- LW, $clog2(N+1), width of the word-count fields. Derived; not overridden.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_startDes  in  1  request deserialisation (may be high together with cmd_startSer).
- cmd_startSer  in  1  request serialisation.
- cmd_numWords  in  LW  word count k of the command; values > N are clamped to N.
- cmd_canReceive  out  1  block idle; a command is accepted this cycle if a start bit is high.
- busy  out  1  transfer or realign in progress.
- buffer_write  out  W*N  next buffer value; the owner registers it every cycle.
- buffer_read  in  W*N  current buffer value.
- des  in  W  incoming word.
- des_isReady  in  1  des valid.
- des_canReceive  out  1  block takes des this cycle if des_isReady.
- des_isLast  out  1  this transfer is word k-1.
- ser  out  W  outgoing word, always buffer_read[W-1:0].
- ser_isReady  out  1  ser valid.
- ser_canReceive  in  1  consumer ready.
- ser_isLast  out  1  equals des_isLast.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
  - Reset clears state to IDLE, counters to 0, mode flags to 0.
  - Reset values: cmd_canReceive=1, busy=0; des_canReceive, ser_isReady, des_isLast, ser_isLast all 0; buffer_write=buffer_read.
- Reset mid-operation aborts the command immediately. The buffer is left as the owner last registered it; no realignment is performed.
- States: IDLE, XFER, ALIGN.
- IDLE:
  - cmd_canReceive=1.
  - accept = cmd_canReceive & (cmd_startSer | cmd_startDes).
  - On accept, the mode flags isSer/isDes and k are latched. They are also used combinationally in the same cycle (zero-latency start), so word 0 may transfer in the accept cycle.
  - If k=0: no transfer, stay IDLE, flags cleared next cycle, no ALIGN.
- XFER:
  - Step condition: isDes&des_isReady when isDes=1 (with ser_canReceive also required if isSer=1); ser_canReceive when ser-only.
  - des_canReceive = isDes & active & (isSer ? ser_canReceive : 1).
  - ser_isReady = isSer & active & (isDes ? des_isReady : ser_canReceive).
  - On a step, the word counter increments and buffer_write is:
    - des mode: {des, buffer_read[W*N-1:W]}
    - ser-only: {buffer_read[W-1:0], buffer_read[W*N-1:W]}
  - With no step, buffer_write = buffer_read.
  - des_isLast = ser_isLast = step on word k-1.
  - Next state: IDLE if k=N, otherwise ALIGN with N-k cycles remaining.
- ALIGN:
  - Each cycle the buffer rotates by one word, as in ser-only, with no external handshake.
  - All stream outputs are 0, cmd_canReceive=0, busy=1.
  - After N-k cycles, go to IDLE.
- Net result:
  - ser outputs words 0..k-1 and leaves the buffer unchanged.
  - des replaces words 0..k-1 (word 0 first) and preserves words k..N-1.
  - ser+des swaps the same words.
- Command latency: k handshake cycles + (N-k) ALIGN cycles. The next command can be accepted in the cycle after the last ALIGN or last-word cycle.
- Start requests while cmd_canReceive=0 are ignored, not queued.
- The counter wraps never; the counter width LW covers N.

Test Plan:
- W=8, N=4, buffer 0x44332211. ser k=4, ser_canReceive=1 -> ser=11,22,33,44 on consecutive cycles, ser_isLast on 44, buffer returns to 0x44332211, cmd_canReceive high on cycle 5.
- des k=2, des stream AA,BB, des_isReady=1 -> 2 transfer cycles + 2 ALIGN cycles, buffer=0x4433BBAA, des_isLast with BB.
- ser+des k=1, des=EE, ser_canReceive toggling 0,1 -> transfer only when both are high, ser=11, buffer=0x443322EE, 3 ALIGN cycles.
- cmd_numWords=0, then cmd_numWords=7 -> k=0 accepted with no handshake and busy stays 0; k=7 behaves as k=4.
- Assert rst for 1 cycle during ALIGN of des k=1 -> outputs go to reset values asynchronously, cmd_canReceive=1 the cycle after release, and a new ser k=4 completes normally.
- cmd_startSer pulsed during XFER -> ignored, no extra transfers.
